// File: rtl/i2c_poll_pkg.sv
// Shared types and widths for the I2C read poller: state encoding, counter
// widths and the NACK counter saturation value.
package i2c_poll_pkg;

  localparam int PERIOD_W  = 24;
  localparam int TIMEOUT_W = 16;

  localparam logic [7:0] NACK_MAX = 8'd255;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PERIOD,
    GO_HI,
    WAIT_START,
    WAIT_DONE,
    HOLD
  } state_t;

endpackage

// File: rtl/i2c_read_poller_if.sv
// Engine handshake plus downstream sample channel of the poller.
// master = poller side, slave = engine / consumer side.
interface i2c_read_poller_if;

  logic        GO;
  logic        END_OK;
  logic        ACK_OK;
  logic [15:0] DATA16;
  logic [7:0]  END_BYTE;
  logic [15:0] SAMPLE;
  logic        SAMPLE_VALID;
  logic        SAMPLE_READY;

  modport master (
    output GO, END_BYTE, SAMPLE, SAMPLE_VALID,
    input  END_OK, ACK_OK, DATA16, SAMPLE_READY
  );

  modport slave (
    input  GO, END_BYTE, SAMPLE, SAMPLE_VALID,
    output END_OK, ACK_OK, DATA16, SAMPLE_READY
  );

endinterface

// File: rtl/poll_timer.sv
// Saturating period counter: preloaded to PRELOAD at reset so the first
// poll is immediate, cleared at each poll start, flags when PRELOAD is reached.
module poll_timer
  import i2c_poll_pkg::*;
#(
  parameter logic [PERIOD_W-1:0] PRELOAD = 24'd50000
) (
  input  logic PT_CK,
  input  logic RESET_N,
  input  logic clear,
  input  logic count,
  output logic reached
);

  logic [PERIOD_W-1:0] cnt;

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of block order.
  // A clear loads 1 because the clearing cycle is itself the first cycle of
  // the new period; this makes poll starts exactly PRELOAD cycles apart.
  always_ff @(posedge PT_CK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt <= PRELOAD;
    end else if (clear) begin
      cnt <= PERIOD_W'(1);
    end else if (count && (cnt < PRELOAD)) begin
      cnt <= cnt + PERIOD_W'(1);
    end
  end

  assign reached = (cnt >= PRELOAD);

endmodule

// File: rtl/i2c_read_poller.sv
// Periodic GO/END_OK controller for the I2C read engine with a valid/ready
// sample register. Optional transaction timeout: define I2C_POLL_TIMEOUT_EN.
module i2c_read_poller
  import i2c_poll_pkg::*;
#(
  parameter logic [PERIOD_W-1:0] POLL_PERIOD = 24'd50000,
  parameter int                  N_BYTES     = 2
`ifdef I2C_POLL_TIMEOUT_EN
  , parameter logic [TIMEOUT_W-1:0] TIMEOUT  = 16'd4000
`endif
) (
  input  logic                 PT_CK,
  input  logic                 RESET_N,
  input  logic                 EN,
  i2c_read_poller_if.master    bus,
  output logic [7:0]           NACK_CNT,
  output logic                 TIMEOUT_ERR,
  output logic                 BUSY
);

  state_t      state, next_state;
  logic        go_q, go_phase, ack_seen, valid_q;
  logic [15:0] sample_q;
  logic [7:0]  nack_q;
  logic        period_clear, period_reached;
  logic        done_ack, done_nack, take_timeout;

  poll_timer #(.PRELOAD(POLL_PERIOD)) u_timer (
    .PT_CK   (PT_CK),
    .RESET_N (RESET_N),
    .clear   (period_clear),
    .count   (1'b1),
    .reached (period_reached)
  );

  // The engine drops ACK_OK in the cycle it raises END_OK, so the latched
  // copy carries the acknowledge into the completion decision.
  assign done_ack  = (state == WAIT_DONE) && bus.END_OK && (ack_seen || bus.ACK_OK);
  assign done_nack = (state == WAIT_DONE) && bus.END_OK && !(ack_seen || bus.ACK_OK);

`ifdef I2C_POLL_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] to_cnt;
  logic                 to_err_q;
  logic                 waiting;

  assign waiting      = (state == WAIT_START) || (state == WAIT_DONE);
  // A completion arriving in the final allowed cycle still wins.
  assign take_timeout = waiting && !done_ack && !done_nack &&
                        (({1'b0, to_cnt} + {{TIMEOUT_W{1'b0}}, 1'b1}) >= {1'b0, TIMEOUT});

  always_ff @(posedge PT_CK or negedge RESET_N) begin
    if (!RESET_N) begin
      to_cnt   <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_cnt <= waiting ? to_cnt + TIMEOUT_W'(1) : '0;
      if (!EN)               to_err_q <= 1'b0;
      else if (take_timeout) to_err_q <= 1'b1;
    end
  end

  assign TIMEOUT_ERR = to_err_q;
`else
  assign take_timeout = 1'b0;
  assign TIMEOUT_ERR  = 1'b0;
`endif

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:        if (EN && bus.END_OK) next_state = WAIT_PERIOD;
      WAIT_PERIOD: if (!EN) next_state = IDLE;
                   else if (period_reached && bus.END_OK) next_state = GO_HI;
      GO_HI:       if (go_phase) next_state = WAIT_START;
      WAIT_START:  if (take_timeout) next_state = WAIT_PERIOD;
                   else if (!bus.END_OK) next_state = WAIT_DONE;
      WAIT_DONE:   if (done_ack) next_state = HOLD;
                   else if (done_nack || take_timeout) next_state = WAIT_PERIOD;
      HOLD:        if (bus.SAMPLE_READY) next_state = EN ? WAIT_PERIOD : IDLE;
      default:     next_state = IDLE;
    endcase
  end

  assign period_clear = (next_state == GO_HI) && (state != GO_HI);

  always_ff @(posedge PT_CK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      go_q     <= 1'b0;
      go_phase <= 1'b0;
      ack_seen <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      nack_q   <= '0;
    end else begin
      state    <= next_state;
      go_q     <= (state == GO_HI);
      go_phase <= (state == GO_HI) && !go_phase;

      if (period_clear)            ack_seen <= 1'b0;
      else if (state == WAIT_DONE) ack_seen <= ack_seen | bus.ACK_OK;

      if (done_ack) begin
        sample_q <= bus.DATA16;
        valid_q  <= 1'b1;
      end else if ((state == HOLD) && bus.SAMPLE_READY) begin
        valid_q  <= 1'b0;
      end

      if (done_nack && (nack_q != NACK_MAX)) nack_q <= nack_q + 8'd1;
    end
  end

  assign bus.GO           = go_q;
  assign bus.END_BYTE     = 8'(N_BYTES - 1);
  assign bus.SAMPLE       = sample_q;
  assign bus.SAMPLE_VALID = valid_q;
  assign NACK_CNT         = nack_q;
  assign BUSY             = (state != IDLE);

endmodule

// File: tb/tb_i2c_read_poller.sv
// Self-checking bench for i2c_read_poller: randomized behavioural engine,
// scoreboard of expected samples/NACKs, GO timing observed by monitors.
module tb_i2c_read_poller;

  localparam int PERIOD  = 100;
  localparam int TO_CYC  = 200;

  logic       PT_CK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       EN = 1'b0;
  logic [7:0] NACK_CNT;
  logic       TIMEOUT_ERR;
  logic       BUSY;

  i2c_read_poller_if bus ();

  i2c_read_poller #(
    .POLL_PERIOD (24'(PERIOD)),
    .N_BYTES     (2)
`ifdef I2C_POLL_TIMEOUT_EN
    , .TIMEOUT   (16'(TO_CYC))
`endif
  ) dut (
    .PT_CK       (PT_CK),
    .RESET_N     (RESET_N),
    .EN          (EN),
    .bus         (bus),
    .NACK_CNT    (NACK_CNT),
    .TIMEOUT_ERR (TIMEOUT_ERR),
    .BUSY        (BUSY)
  );

  always #5 PT_CK = ~PT_CK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge PT_CK) cyc <= cyc + 1;

  // ---------------- behavioural engine + reference model ----------------
  logic        eng_ack = 1'b1;
  logic        eng_stuck = 1'b0;
  logic        eng_fixed = 1'b0;
  logic [15:0] eng_data = 16'h0;
  logic [15:0] exp_samples[$];
  int          exp_nacks = 0;
  int          busy_len;
  logic [15:0] eng_d;

  initial begin
    bus.END_OK = 1'b1;
    bus.ACK_OK = 1'b0;
    bus.DATA16 = 16'h0;
    forever begin
      do begin @(posedge PT_CK); #1; end while (bus.GO !== 1'b1);
      do begin @(posedge PT_CK); #1; end while (bus.GO !== 1'b0);
      @(posedge PT_CK); #1;
      bus.END_OK = 1'b0;
      bus.DATA16 = 16'($urandom);
      busy_len   = int'($urandom_range(4, 10));
      for (int i = 0; (i < busy_len) || eng_stuck; i++) begin
        @(posedge PT_CK); #1;
        if (eng_ack && (i >= 1)) bus.ACK_OK = 1'b1;
      end
      eng_d = eng_fixed ? eng_data : 16'($urandom);
      bus.DATA16 = eng_d;
      bus.END_OK = 1'b1;
      bus.ACK_OK = 1'b0;
      if (eng_ack) exp_samples.push_back(eng_d);
      else         exp_nacks++;
    end
  end

  // ---------------- monitors (sample on falling edge) ----------------
  int          go_rises[$];
  int          go_lens[$];
  int          valid_rises[$];
  int          valid_lens[$];
  int          endok_rises[$];
  logic [15:0] got_samples[$];
  logic        go_prev = 1'b0, valid_prev = 1'b0, endok_prev = 1'b1;
  int          go_hi = 0, valid_hi = 0;

  always @(negedge PT_CK) begin
    if (bus.GO === 1'b1 && !go_prev) go_rises.push_back(cyc);
    if (bus.GO === 1'b1) go_hi++;
    else if (go_prev) begin go_lens.push_back(go_hi); go_hi = 0; end
    if (bus.SAMPLE_VALID === 1'b1 && !valid_prev) valid_rises.push_back(cyc);
    if (bus.SAMPLE_VALID === 1'b1) valid_hi++;
    else if (valid_prev) begin valid_lens.push_back(valid_hi); valid_hi = 0; end
    if (bus.END_OK === 1'b1 && !endok_prev) endok_rises.push_back(cyc);
    if (bus.SAMPLE_VALID === 1'b1 && bus.SAMPLE_READY === 1'b1) got_samples.push_back(bus.SAMPLE);
    go_prev    = (bus.GO === 1'b1);
    valid_prev = (bus.SAMPLE_VALID === 1'b1);
    endok_prev = (bus.END_OK === 1'b1);
  end

  task automatic flush();
    go_rises.delete(); go_lens.delete(); valid_rises.delete(); valid_lens.delete();
    endok_rises.delete(); got_samples.delete(); exp_samples.delete();
    go_hi = 0; valid_hi = 0;
  endtask

  task automatic apply_reset();
    EN = 1'b0;
    bus.SAMPLE_READY = 1'b0;
    RESET_N = 1'b0;
    repeat (3) @(negedge PT_CK);
    RESET_N = 1'b1;
    @(negedge PT_CK);
    flush();
    exp_nacks = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && BUSY !== 1'b0; i++) @(negedge PT_CK);
    checks++;
    if (BUSY !== 1'b0) begin failures++; $display("FAIL wait_idle BUSY got=%b exp=0", BUSY); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    checks++; if (bus.GO !== 1'b0) begin failures++; $display("FAIL rst_go got=%b exp=0", bus.GO); end
    checks++; if (bus.SAMPLE !== 16'h0) begin failures++; $display("FAIL rst_sample got=%h exp=0000", bus.SAMPLE); end
    checks++; if (bus.SAMPLE_VALID !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.SAMPLE_VALID); end
    checks++; if (NACK_CNT !== 8'd0) begin failures++; $display("FAIL rst_nack got=%0d exp=0", NACK_CNT); end
    checks++; if (TIMEOUT_ERR !== 1'b0) begin failures++; $display("FAIL rst_timeout got=%b exp=0", TIMEOUT_ERR); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", BUSY); end
    checks++; if (bus.END_BYTE !== 8'd1) begin failures++; $display("FAIL end_byte got=%0d exp=1", bus.END_BYTE); end
    repeat (20) @(negedge PT_CK);
    checks++; if (go_rises.size() != 0) begin failures++; $display("FAIL rst_no_go got=%0d exp=0", go_rises.size()); end
  endtask

  task automatic test_single_read();
    apply_reset();
    eng_ack = 1'b1; eng_fixed = 1'b1; eng_data = 16'hA5C3;
    bus.SAMPLE_READY = 1'b1;
    EN = 1'b1;
    for (int i = 0; i < 300 && got_samples.size() < 1; i++) @(negedge PT_CK);
    repeat (3) @(negedge PT_CK);
    EN = 1'b0;
    checks++;
    if (got_samples.size() < 1) begin failures++; $display("FAIL single_sample got=none exp=a5c3"); end
    else if (got_samples[0] !== 16'hA5C3) begin failures++; $display("FAIL single_sample got=%h exp=a5c3", got_samples[0]); end
    checks++;
    if (go_lens.size() < 1 || go_lens[0] != 2) begin failures++; $display("FAIL go_width got=%0d exp=2", (go_lens.size() > 0) ? go_lens[0] : -1); end
    checks++;
    if (valid_rises.size() < 1 || endok_rises.size() < 1 || (valid_rises[0] - endok_rises[0]) != 1) begin
      failures++; $display("FAIL sample_latency got=%0d exp=1",
                           (valid_rises.size() > 0 && endok_rises.size() > 0) ? valid_rises[0] - endok_rises[0] : -1);
    end
    checks++;
    if (valid_lens.size() < 1 || valid_lens[0] != 1) begin failures++; $display("FAIL valid_width got=%0d exp=1", (valid_lens.size() > 0) ? valid_lens[0] : -1); end
    wait_idle();
    eng_fixed = 1'b0;
  endtask

  task automatic test_period();
    flush();
    eng_ack = 1'b1;
    bus.SAMPLE_READY = 1'b1;
    EN = 1'b1;
    for (int i = 0; i < 1000 && got_samples.size() < 5; i++) @(negedge PT_CK);
    EN = 1'b0;
    wait_idle();
    checks++;
    if (go_rises.size() != 5) begin failures++; $display("FAIL period_go_count got=%0d exp=5", go_rises.size()); end
    for (int k = 1; k < 5 && k < go_rises.size(); k++) begin
      checks++;
      if ((go_rises[k] - go_rises[k-1]) != PERIOD) begin
        failures++; $display("FAIL period_gap%0d got=%0d exp=%0d", k, go_rises[k] - go_rises[k-1], PERIOD);
      end
    end
    checks++;
    if (got_samples.size() != exp_samples.size()) begin failures++; $display("FAIL period_sample_count got=%0d exp=%0d", got_samples.size(), exp_samples.size()); end
    for (int k = 0; k < got_samples.size() && k < exp_samples.size(); k++) begin
      checks++;
      if (got_samples[k] !== exp_samples[k]) begin failures++; $display("FAIL period_sample%0d got=%h exp=%h", k, got_samples[k], exp_samples[k]); end
    end
  endtask

  task automatic test_nack();
    int exp_sat;
    apply_reset();
    eng_ack = 1'b0;
    bus.SAMPLE_READY = 1'b1;
    EN = 1'b1;
    for (int i = 0; i < 600 && exp_nacks < 3; i++) @(negedge PT_CK);
    EN = 1'b0;
    repeat (5) @(negedge PT_CK);
    checks++; if (NACK_CNT !== 8'(exp_nacks) || exp_nacks != 3) begin failures++; $display("FAIL nack_cnt3 got=%0d exp=3", NACK_CNT); end
    checks++; if (valid_rises.size() != 0) begin failures++; $display("FAIL nack_no_valid got=%0d exp=0", valid_rises.size()); end
    wait_idle();
    EN = 1'b1;
    for (int i = 0; i < 32000 && exp_nacks < 300; i++) @(negedge PT_CK);
    EN = 1'b0;
    wait_idle();
    exp_sat = (exp_nacks > 255) ? 255 : exp_nacks;
    checks++; if (exp_nacks < 300 || NACK_CNT !== 8'(exp_sat)) begin failures++; $display("FAIL nack_sat got=%0d exp=%0d reads=%0d", NACK_CNT, exp_sat, exp_nacks); end
    eng_ack = 1'b1;
  endtask

  task automatic test_backpressure();
    logic [15:0] held;
    int          n_go, stable_err, rdy_cyc;
    flush();
    eng_ack = 1'b1;
    bus.SAMPLE_READY = 1'b0;
    EN = 1'b1;
    for (int i = 0; i < 300 && bus.SAMPLE_VALID !== 1'b1; i++) @(negedge PT_CK);
    held = bus.SAMPLE;
    n_go = go_rises.size();
    stable_err = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge PT_CK);
      if (bus.SAMPLE !== held || bus.SAMPLE_VALID !== 1'b1) stable_err++;
    end
    checks++; if (stable_err != 0) begin failures++; $display("FAIL hold_stable got=%0d exp=0 bad cycles", stable_err); end
    checks++; if (go_rises.size() != n_go) begin failures++; $display("FAIL hold_no_go got=%0d exp=%0d", go_rises.size(), n_go); end
    checks++;
    if (exp_samples.size() < 1 || held !== exp_samples[0]) begin failures++; $display("FAIL hold_sample got=%h exp=%h", held, (exp_samples.size() > 0) ? exp_samples[0] : 16'hxxxx); end
    bus.SAMPLE_READY = 1'b1;
    rdy_cyc = cyc;
    for (int i = 0; i < 300 && go_rises.size() <= n_go; i++) @(negedge PT_CK);
    checks++;
    if (go_rises.size() <= n_go || n_go < 1) begin failures++; $display("FAIL resume_go got=none exp=go"); end
    else begin
      if ((go_rises[n_go] - rdy_cyc) < 1 || (go_rises[n_go] - rdy_cyc) > 5 || (go_rises[n_go] - go_rises[n_go-1]) < PERIOD) begin
        failures++; $display("FAIL resume_go after_ready=%0d gap=%0d exp_gap>=%0d", go_rises[n_go] - rdy_cyc, go_rises[n_go] - go_rises[n_go-1], PERIOD);
      end
    end
    EN = 1'b0;
    wait_idle();
    checks++;
    if (got_samples.size() != exp_samples.size() || got_samples.size() < 1 || got_samples[0] !== held) begin
      failures++; $display("FAIL hold_delivered got=%0d samples exp=%0d", got_samples.size(), exp_samples.size());
    end
  endtask

  task automatic test_en_drop();
    flush();
    eng_ack = 1'b1;
    bus.SAMPLE_READY = 1'b1;
    EN = 1'b1;
    for (int i = 0; i < 300 && bus.END_OK !== 1'b0; i++) @(negedge PT_CK);
    EN = 1'b0;
    for (int i = 0; i < 100 && got_samples.size() < 1; i++) @(negedge PT_CK);
    checks++;
    if (got_samples.size() < 1 || exp_samples.size() < 1 || got_samples[0] !== exp_samples[0]) begin
      failures++; $display("FAIL en_drop_sample got=%0d samples exp=1", got_samples.size());
    end
    wait_idle();
    repeat (200) @(negedge PT_CK);
    checks++; if (go_rises.size() != 1) begin failures++; $display("FAIL en_drop_no_go got=%0d exp=1", go_rises.size()); end
  endtask

  task automatic test_reset_mid();
    int n_go;
    flush();
    eng_ack = 1'b1;
    bus.SAMPLE_READY = 1'b1;
    EN = 1'b1;
    for (int i = 0; i < 300 && bus.END_OK !== 1'b0; i++) @(negedge PT_CK);
    @(negedge PT_CK);
    RESET_N = 1'b0;
    #1;
    checks++; if (bus.GO !== 1'b0 || bus.SAMPLE_VALID !== 1'b0) begin failures++; $display("FAIL midrst_go_valid got=%b%b exp=00", bus.GO, bus.SAMPLE_VALID); end
    checks++; if (bus.SAMPLE !== 16'h0) begin failures++; $display("FAIL midrst_sample got=%h exp=0000", bus.SAMPLE); end
    checks++; if (NACK_CNT !== 8'd0) begin failures++; $display("FAIL midrst_nack got=%0d exp=0", NACK_CNT); end
    checks++; if (BUSY !== 1'b0 || TIMEOUT_ERR !== 1'b0) begin failures++; $display("FAIL midrst_busy_err got=%b%b exp=00", BUSY, TIMEOUT_ERR); end
    EN = 1'b0;
    repeat (3) @(negedge PT_CK);
    RESET_N = 1'b1;
    n_go = go_rises.size();
    repeat (150) @(negedge PT_CK);
    checks++; if (go_rises.size() != n_go || BUSY !== 1'b0) begin failures++; $display("FAIL midrst_no_go got=%0d exp=%0d busy=%b", go_rises.size(), n_go, BUSY); end
    flush();
  endtask

`ifdef I2C_POLL_TIMEOUT_EN
  task automatic test_timeout();
    int err_cyc, n_go;
    apply_reset();
    eng_ack = 1'b1;
    eng_stuck = 1'b1;
    bus.SAMPLE_READY = 1'b1;
    EN = 1'b1;
    for (int i = 0; i < TO_CYC + 300 && TIMEOUT_ERR !== 1'b1; i++) @(negedge PT_CK);
    err_cyc = cyc;
    checks++; if (TIMEOUT_ERR !== 1'b1) begin failures++; $display("FAIL timeout_set got=%b exp=1", TIMEOUT_ERR); end
    checks++;
    if (go_rises.size() < 1 || (err_cyc - go_rises[0]) < TO_CYC - 5 || (err_cyc - go_rises[0]) > TO_CYC + 10) begin
      failures++; $display("FAIL timeout_delay got=%0d exp~%0d", (go_rises.size() > 0) ? err_cyc - go_rises[0] : -1, TO_CYC);
    end
    n_go = go_rises.size();
    repeat (300) @(negedge PT_CK);
    checks++; if (go_rises.size() != n_go) begin failures++; $display("FAIL timeout_no_go got=%0d exp=%0d", go_rises.size(), n_go); end
    eng_stuck = 1'b0;
    for (int i = 0; i < 200 && go_rises.size() <= n_go; i++) @(negedge PT_CK);
    checks++; if (go_rises.size() <= n_go) begin failures++; $display("FAIL timeout_reissue got=none exp=go"); end
    checks++; if (TIMEOUT_ERR !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%b exp=1", TIMEOUT_ERR); end
    EN = 1'b0;
    repeat (2) @(negedge PT_CK);
    checks++; if (TIMEOUT_ERR !== 1'b0) begin failures++; $display("FAIL timeout_clear got=%b exp=0", TIMEOUT_ERR); end
    wait_idle();
    flush();
  endtask
`endif

  initial begin
    bus.SAMPLE_READY = 1'b0;
    test_reset();
    test_single_read();
    test_period();
    test_nack();
    test_backpressure();
    test_en_drop();
    test_reset_mid();
`ifdef I2C_POLL_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog cycles=%0d exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/i2c_read_poller.md
# i2c_read_poller

Periodic controller that sits directly upstream of the I2C read engine. It drives the engine's GO/END_OK start-done handshake and captures the 16-bit result into a valid/ready sample register for downstream logic. The sample is captured only when the slave acknowledged its address. The block runs on the same PT_CK tick clock as the engine and supplies its END_BYTE input.

## Interface
Parameters:
- POLL_PERIOD, 24'd50000: minimum PT_CK cycles between successive GO assertions.
- N_BYTES, 2: bytes per read (1..2); drives END_BYTE = N_BYTES-1.
- TIMEOUT, 16'd4000: PT_CK cycles allowed from GO deassertion to END_OK rising. Only present with I2C_POLL_TIMEOUT_EN.

Ports:
- PT_CK, in, 1: clock, same tick as the read engine.
- RESET_N, in, 1: asynchronous, active-low reset.
- EN, in, 1: polling enable.
- GO, out, 1: start request to the engine.
- END_OK, in, 1: engine idle/done flag (1 = idle).
- ACK_OK, in, 1: engine address-ACK flag.
- DATA16, in, 16: engine read data.
- END_BYTE, out, 8: constant N_BYTES-1.
- SAMPLE, out, 16: captured data.
- SAMPLE_VALID, out, 1: SAMPLE holds an unconsumed sample.
- SAMPLE_READY, in, 1: downstream accepts SAMPLE.
- NACK_CNT, out, 8: saturating count of NACKed reads.
- TIMEOUT_ERR, out, 1: sticky timeout flag.
- BUSY, out, 1: high in every state except IDLE.

## Operation
States are IDLE, WAIT_PERIOD, GO_HI, WAIT_START, WAIT_DONE and HOLD.
- **IDLE:** GO=0. Go to WAIT_PERIOD when EN=1 and END_OK=1. The period counter is preloaded to POLL_PERIOD, so the first GO issues immediately.
- **WAIT_PERIOD:**
  - The period counter counts since the last GO rise.
  - Go to GO_HI when counter ≥ POLL_PERIOD, END_OK=1 and EN=1.
  - If EN=0, go to IDLE.
- **GO_HI:** GO=1 for exactly 2 cycles, then GO=0 and go to WAIT_START. The period counter clears on entry.
- **WAIT_START:** wait for END_OK=0, then go to WAIT_DONE.
- **WAIT_DONE:**
  - ack_seen |= ACK_OK every cycle; ack_seen is cleared on entry to GO_HI.
  - On END_OK=1: if ack_seen, SAMPLE<=DATA16, SAMPLE_VALID<=1, go to HOLD.
  - Otherwise NACK_CNT increments (saturating at 255) and the block goes to WAIT_PERIOD.
  - ACK_OK is latched because the engine clears it in the same cycle it raises END_OK.
- **HOLD:**
  - On SAMPLE_READY=1 at a clock edge, SAMPLE_VALID<=0 and go to WAIT_PERIOD, or IDLE if EN=0.
  - SAMPLE is stable while SAMPLE_VALID=1.
  - The period keeps counting, so polling stretches rather than overwriting. No sample is ever dropped or overwritten.
- **EN=0 mid-transaction:** the transaction completes and its sample is still delivered. IDLE is entered afterwards.
- **Reset:** GO=0, SAMPLE=0, SAMPLE_VALID=0, NACK_CNT=0, TIMEOUT_ERR=0, BUSY=0, ack_seen=0, state IDLE, period counter = POLL_PERIOD.

## Timing
- GO rises 1 cycle after entering GO_HI and is high for exactly 2 cycles.
- END_OK low must be observed within the WAIT_START window; the engine drops it 2 cycles after GO falls.
- The SAMPLE/SAMPLE_VALID update is registered, 1 cycle after the edge that samples END_OK=1.
- SAMPLE_VALID falls on the edge where SAMPLE_VALID=1 and SAMPLE_READY=1.
- The next GO rise is no earlier than POLL_PERIOD cycles after the previous GO rise.
- END_OK=1 and SAMPLE_READY=1 arriving together are handled in their own states; there is no combinational path from inputs to outputs.

## Configuration
- **I2C_POLL_TIMEOUT_EN defined:**
  - A 16-bit timeout counter runs in WAIT_START and WAIT_DONE combined.
  - On reaching TIMEOUT: TIMEOUT_ERR<=1, go to WAIT_PERIOD, no sample.
  - GO is reissued only after END_OK=1.
  - TIMEOUT_ERR clears only on reset or while EN=0.
- **Not defined:** TIMEOUT_ERR is tied to 0, there is no counter, and the block waits indefinitely.

## Structure
- Package i2c_poll_pkg holds:
  - the state enum;
  - PERIOD_W=24 and TIMEOUT_W=16;
  - the NACK_CNT saturation constant.
- Sub-module poll_timer holds the preloadable saturating period counter (clear, count, reached flag).

## Test plan
- EN=1, engine model ACKs, DATA16=16'hA5C3, SAMPLE_READY=1 → GO high 2 cycles, SAMPLE=16'hA5C3 one cycle after END_OK rises, SAMPLE_VALID for 1 cycle.
- POLL_PERIOD=100, continuous ready → GO rises exactly 100 cycles apart over 5 reads.
- Engine NACKs (ACK_OK never 1) on 3 reads → SAMPLE_VALID stays 0, NACK_CNT=3; after 300 NACKs NACK_CNT=255.
- SAMPLE_READY held 0 for 500 cycles with POLL_PERIOD=100 → no GO while in HOLD, SAMPLE unchanged; GO follows once ready and the period has elapsed.
- With I2C_POLL_TIMEOUT_EN, END_OK stuck 0 → TIMEOUT_ERR=1 after TIMEOUT cycles, no GO until END_OK=1; EN=0 clears the flag.
- RESET_N pulsed low during WAIT_DONE → all outputs at reset values immediately, state IDLE, no spurious GO.
